// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU.
// Single-cycle integer ops finish on the accept edge. MUL/MULH/MULHU use a
// shift-add sequencer and DIV/DIVU/REM/REMU use a restoring divider. Both run
// WORDSIZE iterations on operand magnitudes, and a sign fix-up is folded into
// the last iteration.
//
// Handshake: the ALU accepts an op on a rising edge where IN_VALID && IN_READY.
// IN_READY is high only in IDLE. The result is presented with OUT_VALID and is
// held, with OUT and the flags stable, until a rising edge where
// OUT_VALID && OUT_READY. The FSM then returns to IDLE, so the ALU never
// accepts a new op in the same cycle that a result is taken.
module alu_seq #(
  parameter int WORDSIZE = 32,
  parameter int IMMSIZE  = 20,
  parameter int OPSIZE   = 5,
  parameter int SHW      = $clog2(WORDSIZE)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [WORDSIZE-1:0] A,
  input  logic [WORDSIZE-1:0] B,
  input  logic [OPSIZE-1:0]   OP,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [WORDSIZE-1:0] OUT,
  output logic                V,
  output logic                C,
  output logic                N,
  output logic                Z,
  output logic                BUSY,
  output logic [1:0]          dbg_state
);

  localparam int W  = WORDSIZE;
  localparam int CW = $clog2(WORDSIZE);

  localparam logic [OPSIZE-1:0] OP_ADD   = OPSIZE'(1);
  localparam logic [OPSIZE-1:0] OP_SUB   = OPSIZE'(2);
  localparam logic [OPSIZE-1:0] OP_SLL   = OPSIZE'(3);
  localparam logic [OPSIZE-1:0] OP_SRL   = OPSIZE'(4);
  localparam logic [OPSIZE-1:0] OP_SRA   = OPSIZE'(5);
  localparam logic [OPSIZE-1:0] OP_SLU   = OPSIZE'(6);
  localparam logic [OPSIZE-1:0] OP_SLT   = OPSIZE'(7);
  localparam logic [OPSIZE-1:0] OP_OR    = OPSIZE'(8);
  localparam logic [OPSIZE-1:0] OP_AND   = OPSIZE'(9);
  localparam logic [OPSIZE-1:0] OP_XOR   = OPSIZE'(10);
  localparam logic [OPSIZE-1:0] OP_SIU   = OPSIZE'(11);
  localparam logic [OPSIZE-1:0] OP_MUL   = OPSIZE'(12);
  localparam logic [OPSIZE-1:0] OP_MULH  = OPSIZE'(13);
  localparam logic [OPSIZE-1:0] OP_MULHU = OPSIZE'(14);
  localparam logic [OPSIZE-1:0] OP_DIV   = OPSIZE'(15);
  localparam logic [OPSIZE-1:0] OP_DIVU  = OPSIZE'(16);
  localparam logic [OPSIZE-1:0] OP_REM   = OPSIZE'(17);
  localparam logic [OPSIZE-1:0] OP_REMU  = OPSIZE'(18);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_n;
  logic [CW-1:0]     cnt_q;
  logic [W-1:0]      hi_q, lo_q, md_q;   // acc/remainder, multiplier/quotient, multiplicand/divisor
  logic [OPSIZE-1:0] opc_q;
  logic              mul_q, neg_q, negr_q;
  logic [W-1:0]      out_q;
  logic              v_q, c_q, n_q, z_q;

  // Single-cycle result and operand preparation from the live inputs
  logic [W-1:0] sc_res, abs_a, abs_b;
  logic         sc_v, sc_c, iter_op, sgn_op;
  logic [W:0]   sum_w, dif_w;

  // Compute the single-cycle result and the magnitudes/sign info for iterative ops
  always_comb begin
    sc_res  = '0;
    sc_v    = 1'b0;
    sc_c    = 1'b0;
    sum_w   = {1'b0, A} + {1'b0, B};
    dif_w   = {1'b0, A} - {1'b0, B};
    iter_op = (OP >= OP_MUL) && (OP <= OP_REMU);
    sgn_op  = (OP == OP_MULH) || (OP == OP_DIV) || (OP == OP_REM);
    abs_a   = (sgn_op && A[W-1]) ? -A : A;
    abs_b   = (sgn_op && B[W-1]) ? -B : B;
    case (OP)
      OP_ADD: begin
        sc_res = sum_w[W-1:0];
        sc_c   = sum_w[W];
        sc_v   = (A[W-1] == B[W-1]) && (sum_w[W-1] != A[W-1]);
      end
      OP_SUB: begin
        sc_res = dif_w[W-1:0];
        sc_c   = dif_w[W];
        sc_v   = (A[W-1] != B[W-1]) && (dif_w[W-1] != A[W-1]);
      end
      OP_SLL: sc_res = A << B[SHW-1:0];
      OP_SRL: sc_res = A >> B[SHW-1:0];
      OP_SRA: sc_res = $signed(A) >>> B[SHW-1:0];
      OP_SLU: sc_res = {{(W-1){1'b0}}, (A < B)};
      OP_SLT: sc_res = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_OR:  sc_res = A | B;
      OP_AND: sc_res = A & B;
      OP_XOR: sc_res = A ^ B;
      OP_SIU: sc_res = A << (W - IMMSIZE);
      default: sc_res = '0;
    endcase
  end

  // One sequencer iteration: shift-add step for multiply, restoring step for divide
  logic [W-1:0] hi_n, lo_n, dtrial;
  logic [W:0]   msum, dsh;
  logic         dgo;
  always_comb begin
    hi_n   = hi_q;
    lo_n   = lo_q;
    msum   = '0;
    dsh    = {hi_q, lo_q[W-1]};
    dgo    = 1'b0;
    dtrial = '0;
    if (mul_q) begin
      msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : {(W+1){1'b0}});
      hi_n = msum[W:1];
      lo_n = {msum[0], lo_q[W-1:1]};
    end else begin
      // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend
      dgo    = dsh >= {1'b0, md_q};
      dtrial = dsh[W-1:0] - md_q;
      hi_n   = dgo ? dtrial : dsh[W-1:0];
      lo_n   = {lo_q[W-2:0], dgo};
    end
  end

  // Sign fix-up applied to the final iteration's result
  logic [W-1:0] fin;
  always_comb begin
    fin = '0;
    case (opc_q)
      OP_MUL:   fin = lo_n;
      // High word of the negated 2W-bit product: ~hi plus the carry out of -lo
      OP_MULH:  fin = neg_q ? (~hi_n + {{(W-1){1'b0}}, (lo_n == '0)}) : hi_n;
      OP_MULHU: fin = hi_n;
      OP_DIV:   fin = neg_q ? -lo_n : lo_n;
      OP_DIVU:  fin = lo_n;
      OP_REM:   fin = negr_q ? -hi_n : hi_n;
      OP_REMU:  fin = hi_n;
      default:  fin = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: if (IN_VALID) state_n = iter_op ? CALC : DONE;
      CALC: if (cnt_q == CW'(W - 1)) state_n = DONE;
      DONE: if (OUT_READY) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register, operand capture, iteration and result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      md_q    <= '0;
      opc_q   <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      out_q   <= '0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_n;
      case (state_q)
        IDLE: if (IN_VALID) begin
          if (iter_op) begin
            hi_q   <= '0;
            lo_q   <= abs_a;
            md_q   <= abs_b;
            opc_q  <= OP;
            mul_q  <= (OP <= OP_MULHU);
            // A zero divisor keeps the all-ones quotient unsigned-looking
            neg_q  <= sgn_op && (A[W-1] ^ B[W-1]) && (B != '0);
            negr_q <= sgn_op && A[W-1];
            cnt_q  <= '0;
          end else begin
            out_q <= sc_res;
            v_q   <= sc_v;
            c_q   <= sc_c;
            n_q   <= sc_res[W-1];
            z_q   <= (sc_res == '0);
          end
        end
        CALC: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            out_q <= fin;
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            n_q   <= fin[W-1];
            z_q   <= (fin == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign BUSY      = (state_q == CALC);
  assign dbg_state = state_q;
  assign OUT       = out_q;
  assign V         = v_q;
  assign C         = c_q;
  assign N         = n_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq (32-bit) against a
// plain-arithmetic reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic         v, c, n, z, busy;
  logic [W-1:0] a, b, out;
  logic [4:0]   op;
  logic [1:0]   dbg_state;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.WORDSIZE(32), .IMMSIZE(20), .OPSIZE(5)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .OP(op), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT(out), .V(v), .C(c), .N(n), .Z(z), .BUSY(busy), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: 64-bit arithmetic straight from the op definitions
  function automatic void model(input logic [4:0] o, input logic [W-1:0] x, y,
                                output logic [W-1:0] r, output logic mv, output logic mc);
    logic [32:0]        s;
    logic [63:0]        up;
    logic signed [63:0] sp;
    r = '0; mv = 1'b0; mc = 1'b0;
    up = {32'b0, x} * {32'b0, y};
    sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    case (o)
      5'd1: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[31:0]; mc = s[32];
        mv = (x[31] == y[31]) && (r[31] != x[31]);
      end
      5'd2: begin
        r = x - y; mc = (x < y);
        mv = (x[31] != y[31]) && (r[31] != x[31]);
      end
      5'd3:  r = x << y[4:0];
      5'd4:  r = x >> y[4:0];
      5'd5:  r = $signed(x) >>> y[4:0];
      5'd6:  r = (x < y) ? 32'd1 : 32'd0;
      5'd7:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      5'd8:  r = x | y;
      5'd9:  r = x & y;
      5'd10: r = x ^ y;
      5'd11: r = x << 12;
      5'd12: r = up[31:0];
      5'd13: r = sp[63:32];
      5'd14: r = up[63:32];
      5'd15: begin
        if (y == 0) r = 32'hffff_ffff;
        else if (x == 32'h8000_0000 && y == 32'hffff_ffff) r = 32'h8000_0000;
        else r = $signed(x) / $signed(y);
      end
      5'd16: r = (y == 0) ? 32'hffff_ffff : x / y;
      5'd17: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hffff_ffff) r = 32'd0;
        else r = $signed(x) % $signed(y);
      end
      5'd18: r = (y == 0) ? x : x % y;
      default: r = '0;
    endcase
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      4: return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  // Driver: issue one op, measure latency, check result, optionally stall output
  task automatic run_op(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold);
    logic [W-1:0] r, er;
    logic mv, mc;
    int lat, bc, g;
    bit iter;
    model(o, x, y, r, mv, mc);
    exp_q.push_back(r);
    iter = (o >= 5'd12) && (o <= 5'd18);
    g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    check("in_ready_before", in_ready, 1);
    in_valid = 1'b1; a = x; b = y; op = o;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 5'($urandom_range(0, 31));
    lat = 1; bc = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency op%0d", o), lat, iter ? 33 : 1);
    check($sformatf("busy_cycles op%0d", o), bc, iter ? 32 : 0);
    er = exp_q.pop_front();
    check($sformatf("out op%0d a=%h b=%h", o, x, y), out, er);
    check($sformatf("flags_vcnz op%0d", o), {v, c, n, z}, {mv, mc, er[W-1], (er == 0)});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; op = 5'd1;
      @(negedge clk);
      check("hold_stable", {out_valid, in_ready, busy, v, c, n, z, out},
            {1'b1, 1'b0, 1'b0, mv, mc, er[W-1], (er == 0), er});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_to_idle", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {out_valid, in_ready, busy, v, c, n, z, out}, {3'b010, 4'b0, 32'b0});
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    // Directed single-cycle ops
    run_op(5'd1, 32'h7fff_ffff, 32'd1, 0);
    run_op(5'd1, 32'hffff_ffff, 32'd1, 0);
    run_op(5'd2, 32'd3, 32'd5, 0);
    run_op(5'd5, 32'h8000_0000, 32'h24, 0);
    run_op(5'd11, 32'h0001_2345, 32'd0, 0);
    run_op(5'd3, 32'h0000_0001, 32'h3f, 0);
    run_op(5'd4, 32'h8000_0000, 32'h21, 0);
    run_op(5'd6, 32'd1, 32'hffff_ffff, 0);
    run_op(5'd7, 32'd1, 32'hffff_ffff, 0);
    run_op(5'd10, 32'hdead_beef, 32'hdead_beef, 0);

    // Directed iterative ops and corner cases
    run_op(5'd13, 32'hffff_ffff, 32'hffff_ffff, 0);
    run_op(5'd12, 32'hffff_ffff, 32'hffff_ffff, 0);
    run_op(5'd14, 32'hffff_ffff, 32'hffff_ffff, 0);
    run_op(5'd13, 32'h8000_0000, 32'h0000_0003, 0);
    run_op(5'd15, 32'hffff_fff9, 32'd2, 0);
    run_op(5'd17, 32'hffff_fff9, 32'd2, 0);
    run_op(5'd16, 32'd5, 32'd0, 0);
    run_op(5'd18, 32'd5, 32'd0, 0);
    run_op(5'd15, 32'hffff_fff9, 32'd0, 0);
    run_op(5'd17, 32'hffff_fff9, 32'd0, 0);
    run_op(5'd15, 32'h8000_0000, 32'hffff_ffff, 0);
    run_op(5'd17, 32'h8000_0000, 32'hffff_ffff, 0);

    // Backpressure with ignored input pulses
    run_op(5'd15, 32'hffff_fff9, 32'd2, 10);

    // Reset in the middle of a divide
    in_valid = 1'b1; a = 32'hffff_fff9; b = 32'd2; op = 5'd15;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_calc_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_by_reset", {out_valid, busy, in_ready, out}, {3'b001, 32'b0});
    run_op(5'd1, 32'd2, 32'd2, 0);
    run_op(5'd25, 32'h1234_5678, 32'h9abc_def0, 0);
    run_op(5'd0, 32'hffff_ffff, 32'hffff_ffff, 0);

    // Random ops, including illegal opcodes
    for (int k = 0; k < 40; k++) begin
      run_op(5'($urandom_range(0, 31)), rand_operand(), rand_operand(), $urandom_range(0, 2));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
